// File: rtl/mac_alu_pipe.sv
// mac_alu_pipe: two-stage unsigned MUL/ADD/MAC/CLR pipeline with sleep handshake; `ACC_RETENTION_EN keeps acc/overflow across sleep
module mac_alu_pipe #(
  parameter int NBITS = 8,
  parameter int ACC_GUARD = 8,
  localparam int OUTW = 2 * NBITS + ACC_GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  input  logic [1:0]       OP_CODE,
  output logic             out_valid,
  output logic [OUTW-1:0]  O,
  output logic             overflow,
  input  logic             sleep_req,
  output logic             sleep_ack
);
  localparam logic [1:0] MUL = 2'd0, ADD = 2'd1, MAC = 2'd2, CLR = 2'd3;
  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_e;
  state_e state_q;
  logic s1_q, ov_q, ovf_q, ovf_d, sat, take;
  logic [NBITS-1:0] a_q, b_q;
  logic [1:0] op_q;
  logic [OUTW-1:0] acc_q, acc_d, o_q, o_d, prod, sum_ab, mac;
  logic [OUTW:0] sum;
  assign in_ready = state_q == RUN;
  assign sleep_ack = state_q == SLEEP;
  assign take = in_valid && in_ready;
  assign out_valid = ov_q;
  assign O = o_q;
  assign overflow = ovf_q;
  // Power FSM; DRAIN may sleep once S1 is empty since S2 empties at the same edge
  always_ff @(posedge clk)
    if (rst) state_q <= RUN;
    else
      case (state_q)
        RUN:     state_q <= sleep_req ? DRAIN : RUN;
        DRAIN:   state_q <= !sleep_req ? RUN : !s1_q ? SLEEP : DRAIN;
        SLEEP:   state_q <= sleep_req ? SLEEP : WAKE;
        default: state_q <= RUN;
      endcase
  // S1 operand capture
  always_ff @(posedge clk) begin
    s1_q <= !rst && take;
    if (take) begin
      a_q <= A;
      b_q <= B;
      op_q <= OP_CODE;
    end
  end
  // S2 result and saturating accumulator next-state
  always_comb begin
    prod = OUTW'(a_q) * OUTW'(b_q);
    sum_ab = OUTW'(a_q) + OUTW'(b_q);
    sum = {1'b0, acc_q} + {1'b0, prod};
    sat = sum[OUTW];
    mac = sat ? '1 : sum[OUTW-1:0];
    o_d = op_q == MUL ? prod : op_q == ADD ? sum_ab : op_q == MAC ? mac : '0;
    acc_d = op_q == MAC ? mac : op_q == CLR ? '0 : acc_q;
    ovf_d = op_q == CLR ? 1'b0 : ovf_q | (op_q == MAC && sat);
  end
  // S2 registers; without retention the accumulator state is rebuilt from zero on wake
  always_ff @(posedge clk)
    if (rst) begin
      ov_q <= 1'b0;
      o_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ov_q <= s1_q;
      if (s1_q) begin
        o_q <= o_d;
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
`ifndef ACC_RETENTION_EN
      if (state_q == WAKE) begin
        o_q <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
`endif
    end
endmodule
